// File: rtl/fp16_unpack_normalize.sv
// fp16_unpack_normalize
//   Accepts an IEEE-754 half-precision word over a valid/ready handshake.
//   The word is unpacked into sign, biased exponent, explicit-leading-bit
//   mantissa and class flags. Subnormal inputs are then normalised by a
//   one-bit left shift per clock until the mantissa MSB is set.
//
// Ports
//   clk        : clock; all state updates on the rising edge
//   rst        : asynchronous active-low reset
//   in_data    : half word {sign, exp[4:0], frac[9:0]}
//   in_valid   : input word valid
//   in_ready   : block can take a word this cycle
//   out_valid  : result valid (only in the output state)
//   out_ready  : consumer takes the result this cycle
//   sign_out   : sign of the accepted word
//   exp_out    : 7-bit two's complement biased exponent (may be <= 0)
//   mant_out   : 11-bit mantissa with explicit leading bit
//   is_zero    : input was +/-0
//   is_inf     : input was +/-infinity
//   is_nan     : input was a NaN
//   norm_shift : number of left shifts applied during normalisation

module fp16_unpack_normalize (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        sign_out,
    output logic [6:0]  exp_out,
    output logic [10:0] mant_out,
    output logic        is_zero,
    output logic        is_inf,
    output logic        is_nan,
    output logic [3:0]  norm_shift
);

    typedef enum logic [1:0] {StIdle, StNorm, StOut} state_e;

    state_e      state_q, state_d;

    logic        sign_q, sign_d;
    logic [6:0]  exp_q, exp_d;
    logic [10:0] mant_q, mant_d;
    logic        zero_q, zero_d;
    logic        inf_q, inf_d;
    logic        nan_q, nan_d;
    logic [3:0]  shift_q, shift_d;

    // Decoded view of the incoming word, used whenever a word is accepted
    logic        ld_sign;
    logic [6:0]  ld_exp;
    logic [10:0] ld_mant;
    logic        ld_zero, ld_inf, ld_nan;
    state_e      ld_state;

    logic        accept;

    // ------------------------------------------------------------------
    // Input decode
    // ------------------------------------------------------------------
    always_comb begin
        ld_sign  = in_data[15];
        ld_exp   = {2'b00, in_data[14:10]};
        ld_mant  = {1'b1, in_data[9:0]};
        ld_zero  = 1'b0;
        ld_inf   = 1'b0;
        ld_nan   = 1'b0;
        ld_state = StOut;
        if (in_data[14:10] == 5'd0) begin
            if (in_data[9:0] == 10'd0) begin
                ld_exp  = 7'd0;
                ld_mant = 11'd0;
                ld_zero = 1'b1;
            end else begin
                // Subnormal: start at exponent 1 with hidden bit clear,
                // NORM walks it down one shift per clock.
                ld_exp   = 7'd1;
                ld_mant  = {1'b0, in_data[9:0]};
                ld_state = StNorm;
            end
        end else if (in_data[14:10] == 5'd31) begin
            ld_inf = (in_data[9:0] == 10'd0);
            ld_nan = (in_data[9:0] != 10'd0);
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) state_d = ld_state;
            end
            StNorm: begin
                // Leave on the shift that moves a one into bit 10
                if (mant_q[9]) state_d = StOut;
            end
            StOut: begin
                if (out_ready) state_d = in_valid ? ld_state : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = (state_q == StIdle) || ((state_q == StOut) && out_ready);
        out_valid = (state_q == StOut);
    end

    assign accept = in_valid & in_ready;

    // ------------------------------------------------------------------
    // Datapath next state
    // ------------------------------------------------------------------
    always_comb begin
        sign_d  = sign_q;
        exp_d   = exp_q;
        mant_d  = mant_q;
        zero_d  = zero_q;
        inf_d   = inf_q;
        nan_d   = nan_q;
        shift_d = shift_q;
        if (accept) begin
            sign_d  = ld_sign;
            exp_d   = ld_exp;
            mant_d  = ld_mant;
            zero_d  = ld_zero;
            inf_d   = ld_inf;
            nan_d   = ld_nan;
            shift_d = 4'd0;
        end else if (state_q == StNorm) begin
            mant_d  = {mant_q[9:0], 1'b0};
            exp_d   = exp_q - 7'd1;
            shift_d = shift_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sign_q  <= 1'b0;
            exp_q   <= 7'd0;
            mant_q  <= 11'd0;
            zero_q  <= 1'b0;
            inf_q   <= 1'b0;
            nan_q   <= 1'b0;
            shift_q <= 4'd0;
        end else begin
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            mant_q  <= mant_d;
            zero_q  <= zero_d;
            inf_q   <= inf_d;
            nan_q   <= nan_d;
            shift_q <= shift_d;
        end
    end

    assign sign_out   = sign_q;
    assign exp_out    = exp_q;
    assign mant_out   = mant_q;
    assign is_zero    = zero_q;
    assign is_inf     = inf_q;
    assign is_nan     = nan_q;
    assign norm_shift = shift_q;

endmodule

// File: tb/tb_fp16_unpack_normalize.sv
// Scoreboard bench for fp16_unpack_normalize: the driver pushes hand-computed
// expected results when a word is accepted; the monitor pops and compares on
// every output handshake, also checking latency and stability under stall.

module tb_fp16_unpack_normalize;

    logic        clk;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic        sign_out;
    logic [6:0]  exp_out;
    logic [10:0] mant_out;
    logic        is_zero;
    logic        is_inf;
    logic        is_nan;
    logic [3:0]  norm_shift;

    fp16_unpack_normalize dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sign_out   (sign_out),
        .exp_out    (exp_out),
        .mant_out   (mant_out),
        .is_zero    (is_zero),
        .is_inf     (is_inf),
        .is_nan     (is_nan),
        .norm_shift (norm_shift)
    );

    typedef struct {
        logic        s;
        logic [6:0]  e;
        logic [10:0] m;
        logic        z;
        logic        i;
        logic        n;
        logic [3:0]  sh;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Monitor: compares every cycle out_valid is high, pops on handshake
    initial begin : monitor
        exp_t e;
        bit   seen;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst && out_valid) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: out_valid=1 expected no result (t=%0t)",
                             $time);
                end else begin
                    e = q[0];
                    if (!seen) begin
                        seen = 1'b1;
                        chk("latency", cyc - e.acc + 1, e.lat);
                    end
                    chk("sign_out", {31'd0, sign_out}, {31'd0, e.s});
                    chk("exp_out", {25'd0, exp_out}, {25'd0, e.e});
                    chk("mant_out", {21'd0, mant_out}, {21'd0, e.m});
                    chk("flags", {29'd0, is_zero, is_inf, is_nan}, {29'd0, e.z, e.i, e.n});
                    chk("norm_shift", {28'd0, norm_shift}, {28'd0, e.sh});
                    if (out_ready) begin
                        void'(q.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    // Called just after a negedge; returns just after the negedge following acceptance
    task automatic send(input logic [15:0] d, input logic s, input logic [6:0] e,
                        input logic [10:0] m, input logic z, input logic i, input logic n,
                        input logic [3:0] sh, input int lat);
        exp_t x;
        int   k;
        in_data  = d;
        in_valid = 1'b1;
        #1;
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready=0 expected 1 for word 0x%04h", d);
        end else begin
            x.s = s; x.e = e; x.m = m; x.z = z; x.i = i; x.n = n; x.sh = sh;
            x.lat = lat;
            x.acc = cyc + 1;
            q.push_back(x);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin : driver
        int k;
        rst       = 1'b0;
        in_data   = 16'h0000;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #2;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_outputs", {sign_out, exp_out, mant_out, is_zero, is_inf, is_nan, norm_shift},
            32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Normal values
        send(16'h3C00, 1'b0, 7'd15, 11'h400, 1'b0, 1'b0, 1'b0, 4'd0, 1);
        send(16'h7BFF, 1'b0, 7'd30, 11'h7FF, 1'b0, 1'b0, 1'b0, 4'd0, 1);
        @(negedge clk);

        // Smallest subnormal; a pending word is held off throughout NORM
        send(16'h0001, 1'b0, 7'h77, 11'h400, 1'b0, 1'b0, 1'b0, 4'd10, 11);
        in_data  = 16'h3C00;
        in_valid = 1'b1;
        for (int j = 0; j < 10; j++) begin
            #1;
            chk("norm_in_ready", {31'd0, in_ready}, 32'd0);
            chk("norm_out_valid", {31'd0, out_valid}, 32'd0);
            @(negedge clk);
        end
        // Held word is taken on the same edge the subnormal result leaves
        send(16'h3C00, 1'b0, 7'd15, 11'h400, 1'b0, 1'b0, 1'b0, 4'd0, 1);
        @(negedge clk);

        send(16'h8200, 1'b1, 7'd0, 11'h400, 1'b0, 1'b0, 1'b0, 4'd1, 2);
        send(16'h0155, 1'b0, 7'h7F, 11'h554, 1'b0, 1'b0, 1'b0, 4'd2, 3);

        // Specials back to back
        send(16'h7C00, 1'b0, 7'd31, 11'h400, 1'b0, 1'b1, 1'b0, 4'd0, 1);
        send(16'hFE00, 1'b1, 7'd31, 11'h600, 1'b0, 1'b0, 1'b1, 4'd0, 1);
        send(16'h8000, 1'b1, 7'd0, 11'h000, 1'b1, 1'b0, 1'b0, 4'd0, 1);
        @(negedge clk);
        @(negedge clk);

        // Backpressure: result held for 5 cycles, next word waits
        out_ready = 1'b0;
        send(16'h4000, 1'b0, 7'd16, 11'h400, 1'b0, 1'b0, 1'b0, 4'd0, 1);
        in_data  = 16'hBC00;
        in_valid = 1'b1;
        for (int j = 0; j < 5; j++) begin
            #1;
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        send(16'hBC00, 1'b1, 7'd15, 11'h400, 1'b0, 1'b0, 1'b0, 4'd0, 1);
        @(negedge clk);
        @(negedge clk);

        // Reset mid-NORM: word is discarded, nothing pushed
        in_data  = 16'h0001;
        in_valid = 1'b1;
        #1;
        chk("pre_reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_outputs", {sign_out, exp_out, mant_out, is_zero, is_inf, is_nan, norm_shift},
            32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        send(16'h3C00, 1'b0, 7'd15, 11'h400, 1'b0, 1'b0, 1'b0, 4'd0, 1);

        k = 0;
        while (q.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        #3;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d results outstanding expected 0", q.size());
        end
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
